// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one synchronous single-port memory, one transaction in flight.
// Round-robin by default; define MEM_ARB_FIXED_PRIORITY_EN to give requester 0 fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in,
    input  logic [DATA_WIDTH-1:0]   mem_out,
    output logic                    busy
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_in_q, mem_in_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic                    any_req;
    logic                    accept;
    logic                    grant;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    assign any_req = |req_valid;
    assign accept  = (state_q == StIdle) && any_req;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign grant = ~req_valid[0];
`else
    logic last_grant_q;

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end
`endif

    assign sel_write = req_write[grant];
    assign sel_addr  = grant ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                             : req_addr[0 +: ADDR_WIDTH];
    assign sel_wdata = grant ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                             : req_wdata[0 +: DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_in_d      = mem_in_q;
        rsp_data_d    = rsp_data_q;
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    req_ready[grant] = 1'b1;
                    gnt_d            = grant;
                    mem_write_d      = sel_write;
                    mem_address_d    = sel_addr;
                    mem_in_d         = sel_wdata;
                    state_d          = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // Memory output now holds read data or the write-through echo.
                rsp_data_d = mem_out;
                state_d    = StResp;
            end
            StResp: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Async reset also clears mem_write at once, cancelling a write still in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            gnt_q         <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_in_q      <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_in      = mem_in_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != StIdle);

endmodule
